// File: rtl/prog_patt_det_if.sv
// -----------------------------------------------------------------------------
// prog_patt_det_if
// Signal bundle for the programmable serial pattern detector.
//   Config : cfg_load, cfg_pattern[MAX_BITS], cfg_len[LEN_W], cfg_overlap
//   Stream : valid, data (1-bit serial sample, qualified by valid)
//   Counter: cnt_clr
//   Status : detect, match_cnt[CNT_W], cnt_sat, cfg_err, state[2]
// Handshake: a data bit is consumed on every rising clock edge where valid=1
// and cfg_load=0; there is no ready/back-pressure, the detector always
// accepts. cfg_load is a one-cycle strobe that wins over valid.
// Modports: master drives config/stream/cnt_clr, slave is the detector.
// -----------------------------------------------------------------------------
interface prog_patt_det_if #(
  parameter int MAX_BITS = 16,
  parameter int LEN_W    = $clog2(MAX_BITS) + 1,
  parameter int CNT_W    = 8
);
  logic                cfg_load;
  logic [MAX_BITS-1:0] cfg_pattern;
  logic [LEN_W-1:0]    cfg_len;
  logic                cfg_overlap;
  logic                valid;
  logic                data;
  logic                cnt_clr;
  logic                detect;
  logic [CNT_W-1:0]    match_cnt;
  logic                cnt_sat;
  logic                cfg_err;
  logic [1:0]          state;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, valid, data, cnt_clr,
    input  detect, match_cnt, cnt_sat, cfg_err, state
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, valid, data, cnt_clr,
    output detect, match_cnt, cnt_sat, cfg_err, state
  );
endinterface

// File: rtl/prog_patt_det.sv
// -----------------------------------------------------------------------------
// prog_patt_det
// Runtime-programmable serial pattern detector with saturating match counter.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : prog_patt_det_if.slave (config, serial stream, counter clear, status)
// The received bits are kept in a sliding history register and compared
// against the latched pattern under a length mask, so any length 2..MAX_BITS
// is handled without per-prefix states. state: 0 IDLE, 1 FILL, 2 RUN.
// -----------------------------------------------------------------------------
module prog_patt_det #(
  parameter int MAX_BITS = 16,
  parameter int LEN_W    = $clog2(MAX_BITS) + 1,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rstn,
  prog_patt_det_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  logic [MAX_BITS-1:0] r_pat;
  logic [LEN_W-1:0]    r_len;
  logic                r_ovl;
  // The oldest bit of a full-width window is never needed again once the new
  // bit shifts in, so only MAX_BITS-1 bits of history are stored.
  logic [MAX_BITS-2:0] r_hist;
  logic [LEN_W-1:0]    r_fill;
  logic                r_detect;
  logic                r_cfg_err;
  logic [CNT_W-1:0]    r_cnt;

  logic [MAX_BITS-1:0] w_hist_next;
  logic [MAX_BITS-1:0] w_mask;
  logic [LEN_W-1:0]    w_fill_inc;
  logic                w_len_ok;
  logic                w_shift;
  logic                w_match;

  assign w_hist_next = {r_hist, bus.data};
  assign w_fill_inc  = r_fill + LEN_W'(1);
  assign w_len_ok    = (bus.cfg_len >= LEN_MIN) && (bus.cfg_len <= LEN_MAX);
  // A sample is consumed only when no config load competes for the cycle.
  assign w_shift     = bus.valid && !bus.cfg_load && (r_state != ST_IDLE);

  // Bits at or above the programmed length are excluded from the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_match = w_shift && (w_fill_inc >= r_len) &&
                   (((w_hist_next ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_detect  <= 1'b0;
      r_cfg_err <= 1'b0;
      if (bus.cfg_load) begin
        r_pat  <= bus.cfg_pattern;
        r_len  <= bus.cfg_len;
        r_ovl  <= bus.cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
        if (w_len_ok) begin
          r_state <= ST_FILL;
        end else begin
          r_state   <= ST_IDLE;
          r_cfg_err <= 1'b1;
        end
      end else if (w_shift) begin
        r_hist <= w_hist_next[MAX_BITS-2:0];
        if (w_match) begin
          r_detect <= 1'b1;
          if (r_ovl) begin
            r_fill  <= r_len;
            r_state <= ST_RUN;
          end else begin
            // Non-overlapping: the next match must be built from fresh bits.
            r_fill  <= '0;
            r_state <= ST_FILL;
          end
        end else if (w_fill_inc >= r_len) begin
          r_fill  <= r_len;
          r_state <= ST_RUN;
        end else begin
          r_fill  <= w_fill_inc;
          r_state <= ST_FILL;
        end
      end
    end
  end

  // Counter moves on the same edge that raises detect; a clear that coincides
  // with a match keeps that match as the first count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.detect    = r_detect;
  assign bus.match_cnt = r_cnt;
  assign bus.cnt_sat   = (r_cnt == CNT_MAX);
  assign bus.cfg_err   = r_cfg_err;
  assign bus.state     = r_state;

endmodule

// File: doc/prog_patt_det.md
Name: prog_patt_det

Overview:
Parametrised, runtime-programmable serial pattern detector. It is the successor to the fixed 5-bit explicit-FSM detector. Pattern, pattern length and overlap/non-overlap mode are loaded through a config port instead of being fixed at elaboration or taken from plusargs. The block also keeps a saturating match counter. It sits on a 1-bit qualified serial stream (data/valid) and emits a registered one-cycle detect pulse.

Parameters:
MAX_BITS, 16, maximum supported pattern length (legal range 2..64)
LEN_W, $clog2(MAX_BITS)+1, width of length field
CNT_W, 8, width of match counter

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_BITS  pattern; bit [cfg_len-1] = first bit received, bit [0] = last
cfg_len  in  LEN_W  pattern length, legal 2..MAX_BITS
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
valid  in  1  data qualifier
data  in  1  serial input bit
cnt_clr  in  1  clears match counter
detect  out  1  one-cycle pulse, registered
match_cnt  out  CNT_W  number of detections, saturating
cnt_sat  out  1  high while match_cnt is all ones
cfg_err  out  1  one-cycle pulse on illegal cfg_len
state  out  2  FSM state: 0 IDLE, 1 FILL, 2 RUN

Behaviour:
- Reset (rstn low, async): state=IDLE, detect=0, match_cnt=0, cnt_sat=0, cfg_err=0. History register, fill counter and latched config are all cleared.
- IDLE: ignores valid and data. Exits only on cfg_load.
- cfg_load is honoured in any state and has priority over valid in the same cycle; that cycle's sample is dropped.
  - On cfg_load: latch the config, clear history, fill=0, detect=0.
  - Legal len (2..MAX_BITS): state goes to FILL.
  - Illegal len: state goes to IDLE and cfg_err pulses high for 1 cycle. Latched config is invalid.
  - match_cnt is not affected by cfg_load.
- On valid=1 (no cfg_load):
  - hist <= {hist[MAX_BITS-2:0], data}.
  - fill <= min(fill+1, len).
  - Cycles with valid=0 hold all state; detect is 0 in those cycles.
- Match condition: the updated window hist_next[len-1:0] equals pattern[len-1:0], and fill+1 >= len. Bits above len are masked.
- Latency: detect=1 in the cycle after the clock edge that samples the completing bit. It is a single-cycle pulse even on back-to-back matches (consecutive pulses are allowed).
- FILL -> RUN when fill reaches len.
- Overlap mode: fill stays saturated at len after a match; every subsequent valid bit can complete a new match.
- Non-overlap mode: after a match, fill goes to 0 and state goes to FILL. The next match needs len fresh bits.
- In RUN without a match, fill stays at len (sliding window). Sliding-window comparison replaces per-prefix states; there are no hand-coded prefix states.
- match_cnt increments by 1 on each detect and saturates at 2^CNT_W-1. cnt_sat = (match_cnt == all ones).
- cnt_clr handling:
  - cnt_clr alone: match_cnt goes to 0 next edge.
  - cnt_clr together with a detect: match_cnt goes to 1, so the event is not lost.
- Reset asserted mid-stream: immediate return to the reset values above. Config must be reloaded.

Test Plan:
- Overlap: cfg_len=5, pattern=5'b10110, cfg_overlap=1; stream 1,0,1,1,0,1,1,0 with valid=1 -> detect one cycle after samples 5 and 8; match_cnt=2.
- Non-overlap: same stream with cfg_overlap=0 -> detect only after sample 5; match_cnt=1; state FILL after sample 5.
- Pattern 3'b111, len=3, stream of five 1s -> overlap: 3 detects (after samples 3,4,5). Non-overlap: 1 detect (after sample 3).
- Valid gaps: stream 10110 with valid low for 3 cycles between each bit -> exactly one detect, one cycle after the 5th valid sample. Invalid cycles do not shift history.
- Saturation and clear, CNT_W=2, overlap 111 over 7 ones -> match_cnt 3 and cnt_sat=1 after the 4th detect. Then cnt_clr coincident with a detect -> match_cnt=1, cnt_sat=0.
- Config errors and reset:
  - cfg_len=1 -> cfg_err pulse, state IDLE, no detect on any stream.
  - rstn low mid-stream after 4 of 5 pattern bits -> outputs 0 immediately; after reload, no spurious detect from old history.
